iir_biquad_cascade: RTL and testbench

Time-multiplexed cascade of `N_SECTIONS` Direct-Form-I biquad sections serving `N_CH` interleaved audio channels through one shared multiply-accumulate unit. Next-generation audio filter core: sits between the I2S receive deserialiser and the transmit serialiser. Adds over the single-section, single-channel filter:
- parametrised data and coefficient widths
- per-channel filter history
- a run-time coefficient write port
- a valid/ready handshake

---
 rtl/iir_pkg.sv | 61 ++++++
 rtl/iir_biquad_cascade_if.sv | 34 +++
 rtl/iir_mac_unit.sv | 38 +++
 rtl/iir_biquad_cascade.sv | 208 ++++++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the biquad cascade filter core.
// Optional build macro used by the core: IIR_SAT_EN (saturating write-back).
package iir_pkg;

  // Controller states of the time-multiplexed cascade.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_WB,
    ST_DONE
  } state_t;

  // MAC tap sequence; also the coefficient order inside one section.
  typedef enum logic [2:0] {
    TAP_B0,
    TAP_B1,
    TAP_B2,
    TAP_A1,
    TAP_A2
  } tap_t;

  localparam int K_B0   = 0;
  localparam int K_B1   = 1;
  localparam int K_B2   = 2;
  localparam int K_A1   = 3;
  localparam int K_A2   = 4;
  localparam int N_COEF = 5;

  // Round half up, then drop the coefficient fraction bits.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (v + half) >>> frac;
  endfunction

  // Clamp to a w-bit signed range when sat is set; otherwise pass through so
  // the caller's truncation gives two's-complement wrap.
  function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                input int w,
                                                input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

  // True when v does not fit in a w-bit signed value.
  function automatic bit out_of_range(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample, coefficient and result bus of the biquad cascade filter core.
// The master side is the upstream/control logic, the slave side the filter.
interface iir_biquad_cascade_if #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int N_SECTIONS = 3,
  parameter int N_CH       = 2
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ADDR_W = $clog2(5 * N_SECTIONS);

  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     hist_clr;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [DATA_W-1:0] out_data;
  logic                     sat_flag;

  modport master (
    output in_valid, in_ch, in_data, coef_we, coef_addr, coef_data, hist_clr,
    input  in_ready, out_valid, out_ch, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_ch, in_data, coef_we, coef_addr, coef_data, hist_clr,
    output in_ready, out_valid, out_ch, out_data, sat_flag
  );
endinterface

// File: rtl/iir_mac_unit.sv
// Shared multiply-accumulate unit: one exact signed product per enabled
// cycle, added to or subtracted from a registered accumulator.
module iir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = DATA_W + COEF_W + 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     ce,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [ACC_W-1:0]  acc
);
  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // Full-precision product, sign-extended to the accumulator width.
  always_comb begin
    prod     = PROD_W'(coef) * PROD_W'(data);
    prod_ext = ACC_W'(prod);
  end

  // Clear has priority so a new section always starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (ce) begin
      acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
    end
  end
endmodule

// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed Direct-Form-I biquad cascade for interleaved channels.
// Build macro IIR_SAT_EN: clamp out-of-range write-back results and keep a
// sticky sat_flag; without it results wrap and sat_flag is tied low.
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int FRAC_BITS  = 14,
  parameter int N_SECTIONS = 3,
  parameter int N_CH       = 2,
  parameter int ACC_W      = DATA_W + COEF_W + 4
) (
  input  logic                 clk,
  input  logic                 reset,
  iir_biquad_cascade_if.slave  bus
);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ADDR_W  = $clog2(5 * N_SECTIONS);
  localparam int N_COEFS = N_COEF * N_SECTIONS;
  localparam int N_HIST  = N_CH * N_SECTIONS;
  localparam int HIDX_W  = (N_HIST > 1) ? $clog2(N_HIST) : 1;
  localparam int SEC_W   = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(2 ** FRAC_BITS);
`ifdef IIR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t                   state;
  tap_t                     tap;
  logic [SEC_W-1:0]         sec;
  logic [CH_W-1:0]          ch_reg;
  logic signed [DATA_W-1:0] sec_x;

  logic signed [COEF_W-1:0] coef_mem [N_COEFS];
  logic signed [DATA_W-1:0] hx1 [N_HIST];
  logic signed [DATA_W-1:0] hx2 [N_HIST];
  logic signed [DATA_W-1:0] hy1 [N_HIST];
  logic signed [DATA_W-1:0] hy2 [N_HIST];

  logic                     in_ready_r;
  logic                     out_valid_r;
  logic [CH_W-1:0]          out_ch_r;
  logic signed [DATA_W-1:0] out_data_r;
  logic                     sat_r;

  logic [HIDX_W-1:0]        hidx;
  logic [ADDR_W-1:0]        cidx;
  logic signed [COEF_W-1:0] mac_coef;
  logic signed [DATA_W-1:0] mac_data;
  logic                     mac_sub;
  logic                     mac_clr;
  logic                     mac_ce;
  logic                     last_sec;
  logic signed [ACC_W-1:0]  acc;
  logic signed [63:0]       acc_wide;
  logic signed [63:0]       wb_wide;
  logic signed [DATA_W-1:0] wb_res;

  // Operand selection for the current (channel, section, tap) and write-back math.
  always_comb begin
    hidx     = HIDX_W'(int'(ch_reg) * N_SECTIONS + int'(sec));
    cidx     = ADDR_W'(int'(sec) * N_COEF + int'(tap));
    mac_coef = coef_mem[cidx];
    mac_data = sec_x;
    mac_sub  = 1'b0;
    case (tap)
      TAP_B0:  begin mac_data = sec_x;     mac_sub = 1'b0; end
      TAP_B1:  begin mac_data = hx1[hidx]; mac_sub = 1'b0; end
      TAP_B2:  begin mac_data = hx2[hidx]; mac_sub = 1'b0; end
      TAP_A1:  begin mac_data = hy1[hidx]; mac_sub = 1'b1; end
      TAP_A2:  begin mac_data = hy2[hidx]; mac_sub = 1'b1; end
      default: begin mac_data = sec_x;     mac_sub = 1'b0; end
    endcase
    last_sec = (int'(sec) == N_SECTIONS - 1);
    mac_clr  = (state == ST_LOAD) || ((state == ST_WB) && !last_sec);
    mac_ce   = (state == ST_MAC);
    acc_wide = 64'(acc);
    wb_wide  = round_shift(acc_wide, FRAC_BITS);
    wb_res   = DATA_W'(narrow(wb_wide, DATA_W, SAT_EN));
  end

  iir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .ce    (mac_ce),
    .sub   (mac_sub),
    .coef  (mac_coef),
    .data  (mac_data),
    .acc   (acc)
  );

  // Controller: accepts samples and coefficient writes, steps taps and sections, updates history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      tap         <= TAP_B0;
      sec         <= '0;
      ch_reg      <= '0;
      sec_x       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_data_r  <= '0;
      for (int i = 0; i < N_HIST; i++) begin
        hx1[i] <= '0;
        hx2[i] <= '0;
        hy1[i] <= '0;
        hy2[i] <= '0;
      end
      for (int i = 0; i < N_COEFS; i++) begin
        coef_mem[i] <= ((i % N_COEF) == K_B0) ? COEF_ONE : '0;
      end
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.hist_clr) begin
            for (int i = 0; i < N_HIST; i++) begin
              hx1[i] <= '0;
              hx2[i] <= '0;
              hy1[i] <= '0;
              hy2[i] <= '0;
            end
          end
          if (bus.in_valid) begin
            if (int'(bus.in_ch) < N_CH) begin
              ch_reg     <= bus.in_ch;
              sec_x      <= bus.in_data;
              in_ready_r <= 1'b0;
              state      <= ST_LOAD;
            end
          end else if (!bus.hist_clr && bus.coef_we &&
                       (int'(bus.coef_addr) < N_COEFS)) begin
            coef_mem[bus.coef_addr] <= bus.coef_data;
          end
        end
        ST_LOAD: begin
          sec   <= '0;
          tap   <= TAP_B0;
          state <= ST_MAC;
        end
        ST_MAC: begin
          if (tap == TAP_A2) begin
            tap   <= TAP_B0;
            state <= ST_WB;
          end else begin
            tap <= tap.next();
          end
        end
        ST_WB: begin
          hx2[hidx] <= hx1[hidx];
          hx1[hidx] <= sec_x;
          hy2[hidx] <= hy1[hidx];
          hy1[hidx] <= wb_res;
          sec_x     <= wb_res;
          if (last_sec) begin
            out_data_r  <= wb_res;
            out_ch_r    <= ch_reg;
            out_valid_r <= 1'b1;
            state       <= ST_DONE;
          end else begin
            sec   <= sec + 1'b1;
            state <= ST_MAC;
          end
        end
        ST_DONE: begin
          in_ready_r <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IIR_SAT_EN
  logic wb_ovf;
  assign wb_ovf = out_of_range(wb_wide, DATA_W);

  // Sticky saturation flag, set by any clamped write-back until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_r <= 1'b0;
    end else if ((state == ST_WB) && wb_ovf) begin
      sat_r <= 1'b1;
    end
  end
`else
  assign sat_r = 1'b0;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_data  = out_data_r;
  assign bus.sat_flag  = sat_r;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Testbench for iir_biquad_cascade: directed scenarios plus randomized
// samples and coefficients, checked by a scoreboard fed from a reference
// model. Honours IIR_SAT_EN in the same way as the design.
`timescale 1ns/1ps
module tb_iir_biquad_cascade;
  localparam int DATA_W     = 16;
  localparam int COEF_W     = 16;
  localparam int FRAC_BITS  = 14;
  localparam int N_SECTIONS = 3;
  localparam int N_CH       = 2;
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ADDR_W     = $clog2(5 * N_SECTIONS);
  localparam int LATENCY    = 6 * N_SECTIONS + 2;
  localparam longint MAXV   = (64'sd1 <<< (DATA_W - 1)) - 1;
  localparam longint MINV   = -(64'sd1 <<< (DATA_W - 1));
`ifdef IIR_SAT_EN
  localparam bit SAT_MODEL = 1'b1;
`else
  localparam bit SAT_MODEL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  iir_biquad_cascade_if #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .N_SECTIONS(N_SECTIONS), .N_CH(N_CH)
  ) bus ();

  iir_biquad_cascade #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS),
    .N_SECTIONS(N_SECTIONS), .N_CH(N_CH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Reference model state: coefficients per section, history per channel/section.
  int coef_m [N_SECTIONS][5];
  int mx1 [N_CH][N_SECTIONS];
  int mx2 [N_CH][N_SECTIONS];
  int my1 [N_CH][N_SECTIONS];
  int my2 [N_CH][N_SECTIONS];
  bit sat_m;

  typedef struct {
    int     ch;
    int     data;
    bit     sat;
    longint acc_cycle;
  } exp_t;

  exp_t sb[$];

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelClearHistory();
    for (int c = 0; c < N_CH; c++)
      for (int s = 0; s < N_SECTIONS; s++) begin
        mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
      end
  endtask

  task automatic modelReset();
    for (int s = 0; s < N_SECTIONS; s++)
      for (int k = 0; k < 5; k++)
        coef_m[s][k] = (k == 0) ? (1 << FRAC_BITS) : 0;
    modelClearHistory();
    sat_m = 1'b0;
  endtask

  // One sample through the whole cascade using plain integer arithmetic.
  task automatic modelSample(input int ch, input int x, output int y);
    longint acc;
    longint r;
    int     xin;
    xin = x;
    for (int s = 0; s < N_SECTIONS; s++) begin
      acc = longint'(coef_m[s][0]) * xin
          + longint'(coef_m[s][1]) * mx1[ch][s]
          + longint'(coef_m[s][2]) * mx2[ch][s]
          - longint'(coef_m[s][3]) * my1[ch][s]
          - longint'(coef_m[s][4]) * my2[ch][s];
      r = (acc + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
      if (r > MAXV || r < MINV) begin
        if (SAT_MODEL) begin
          sat_m = 1'b1;
          r = (r > MAXV) ? MAXV : MINV;
        end else begin
          r = ((r % (MAXV + 1 - MINV)) + (MAXV + 1 - MINV)) % (MAXV + 1 - MINV);
          if (r > MAXV) r = r - (MAXV + 1 - MINV);
        end
      end
      mx2[ch][s] = mx1[ch][s];
      mx1[ch][s] = xin;
      my2[ch][s] = my1[ch][s];
      my1[ch][s] = int'(r);
      xin = int'(r);
    end
    y = xin;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput("ready_timeout", bus.in_ready, 1);
  endtask

  task automatic writeCoef(input int s, input int k, input logic [15:0] val);
    waitReady();
    bus.coef_we   = 1'b1;
    bus.coef_addr = ADDR_W'(s * 5 + k);
    bus.coef_data = val;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    coef_m[s][k] = int'($signed(val));
  endtask

  task automatic clearHistory();
    waitReady();
    bus.hist_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.hist_clr = 1'b0;
    modelClearHistory();
  endtask

  // Present a sample immediately and hold it until an edge that sees in_ready.
  task automatic applyStimulus(input int ch, input int x);
    bit   rdy;
    int   n;
    int   y;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = CH_W'(ch);
    bus.in_data  = DATA_W'(x);
    do begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (!rdy) @(negedge clk);
      n++;
    end while (!rdy && n < 400);
    bus.in_valid = 1'b0;
    if (!rdy) begin
      checkOutput("accept_timeout", bus.in_ready, 1);
      return;
    end
    e.acc_cycle = cycle_cnt;
    modelSample(ch, x, y);
    e.ch   = ch;
    e.data = y;
    e.sat  = sat_m;
    sb.push_back(e);
    @(negedge clk);
    checkOutput("in_ready_drop", bus.in_ready, 0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", bus.out_valid, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("out_ch", bus.out_ch, e.ch);
        checkOutput("out_data", bus.out_data, e.data);
        checkOutput("sat_flag", bus.sat_flag, e.sat);
        checkOutput("latency", cycle_cnt + 1 - e.acc_cycle, LATENCY);
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.hist_clr  = 1'b0;
    modelReset();

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_ch", bus.out_ch, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_sat_flag", bus.sat_flag, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] passthrough");
    applyStimulus(0, 'h1234);
    waitDrain();

    $display("[TB] half gain");
    writeCoef(0, 0, 16'h2000);
    applyStimulus(0, 'h4000);
    waitDrain();

    $display("[TB] unit delay, channel isolation");
    clearHistory();
    writeCoef(0, 0, 16'h0000);
    writeCoef(0, 1, 16'h4000);
    applyStimulus(0, 100);
    applyStimulus(1, 200);
    applyStimulus(0, 300);
    applyStimulus(1, 400);
    waitDrain();

    $display("[TB] recursive impulse response");
    clearHistory();
    writeCoef(0, 1, 16'h0000);
    writeCoef(0, 0, 16'h4000);
    writeCoef(0, 3, 16'hE000);
    applyStimulus(0, 'h4000);
    repeat (3) applyStimulus(0, 0);
    waitDrain();

    $display("[TB] overflow");
    clearHistory();
    writeCoef(0, 3, 16'h0000);
    for (int s = 0; s < N_SECTIONS; s++) writeCoef(s, 0, 16'h7FFF);
    applyStimulus(0, 'h7FFF);
    waitDrain();

    $display("[TB] randomized samples and coefficients");
    writeCoef(1, 4, 16'h8000);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        writeCoef($urandom_range(0, N_SECTIONS - 1), $urandom_range(0, 4),
                  16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 9) == 0) clearHistory();
      applyStimulus($urandom_range(0, N_CH - 1), int'($urandom_range(0, 65535)) - 32768);
    end
    waitDrain();

    $display("[TB] reset during computation");
    writeCoef(0, 0, 16'h1000);
    applyStimulus(1, 'h0555);
    repeat (8) @(negedge clk);
    sb.delete();
    reset = 1'b0;
    #1;
    checkOutput("abort_out_valid", bus.out_valid, 0);
    checkOutput("abort_out_ch", bus.out_ch, 0);
    checkOutput("abort_out_data", bus.out_data, 0);
    checkOutput("abort_in_ready", bus.in_ready, 1);
    checkOutput("abort_sat_flag", bus.sat_flag, 0);
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(1, 'h1234);
    waitDrain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
